mux4in_decoder4out: RTL and testbench

- Registered combo block: a 4:1 data multiplexer (mux4in function) and a 2-to-4 one-hot decoder (decoder4out function) side by side.
- Both paths share one clock and one synchronous reset. They are otherwise independent.
- Used as a small select/steering primitive: mux picks one of four lanes; decoder generates one-hot strobes from a 2-bit code.

---
 rtl/mux4in_decoder4out.sv | 103 ++++++++++
 tb/tb_mux4in_decoder4out.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/mux4in_decoder4out.sv
// ---------------------------------------------------------------------------
// mux4in_decoder4out
//
// Registered select/steering primitive: a 4:1 data multiplexer and a
// 2-to-4 one-hot decoder sitting side by side. Both share one clock and one
// synchronous active-high reset but are otherwise independent. Each output
// reflects its own inputs as sampled on the previous rising edge.
//
// Parameters:
//   WIDTH     - bit width of each mux lane and of mux_out (>= 1)
//
// Ports:
//   clk       in   1        rising-edge clock
//   rst       in   1        synchronous active-high reset (clears outputs)
//   mux_in    in   4*WIDTH  four data lanes, lane i = mux_in[i*WIDTH +: WIDTH]
//   mux_sel   in   2        lane select
//   mux_out   out  WIDTH    registered selected lane
//   dec_code  in   2        code to decode
//   dec_en    in   1        decoder enable
//   dec_out   out  4        registered one-hot decode (all low when disabled)
//
// Optional build macro MUXDEC_VALID_EN adds:
//   in_valid  in   1        outputs update only on edges where this is high
//   out_valid out  1        in_valid delayed by one edge, cleared by reset
// ---------------------------------------------------------------------------
module mux4in_decoder4out #(
    parameter int WIDTH = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [4*WIDTH-1:0]   mux_in,
    input  logic [1:0]           mux_sel,
    output logic [WIDTH-1:0]     mux_out,
    input  logic [1:0]           dec_code,
    input  logic                 dec_en,
    output logic [3:0]           dec_out
`ifdef MUXDEC_VALID_EN
    ,
    input  logic                 in_valid,
    output logic                 out_valid
`endif
);

    // Split the flat lane bus into an indexable array; lane 0 is the LSB lane.
    logic [WIDTH-1:0] lane [4];
    logic [3:0]       dec_onehot;

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign lane[gi]       = mux_in[gi*WIDTH +: WIDTH];
        // Bit gi fires only when enabled and the code matches its index,
        // so the vector is one-hot when enabled and all-zero otherwise.
        assign dec_onehot[gi] = dec_en && (dec_code == 2'(gi));
    end

    // Update qualifier: every edge in the default build, gated by in_valid
    // when the valid handshake is compiled in.
    logic update_en;
`ifdef MUXDEC_VALID_EN
    assign update_en = in_valid;
`else
    assign update_en = 1'b1;
`endif

    logic [WIDTH-1:0] mux_q, mux_d;
    logic [3:0]       dec_q, dec_d;

    always_comb begin
        mux_d = mux_q;
        dec_d = dec_q;
        if (update_en) begin
            mux_d = lane[mux_sel];
            dec_d = dec_onehot;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mux_q <= '0;
            dec_q <= 4'b0000;
        end else begin
            mux_q <= mux_d;
            dec_q <= dec_d;
        end
    end

    assign mux_out = mux_q;
    assign dec_out = dec_q;

`ifdef MUXDEC_VALID_EN
    logic valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= in_valid;
        end
    end

    assign out_valid = valid_q;
`endif

endmodule

// File: tb/tb_mux4in_decoder4out.sv
module tb_mux4in_decoder4out;

`ifdef MUXDEC_VALID_EN
    localparam int W = 8;
`else
    localparam int W = 1;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic [4*W-1:0]   mux_in;
    logic [1:0]       mux_sel;
    logic [W-1:0]     mux_out;
    logic [1:0]       dec_code;
    logic             dec_en;
    logic [3:0]       dec_out;
`ifdef MUXDEC_VALID_EN
    logic             in_valid;
    logic             out_valid;
`endif

    int n_vec  = 0;
    int n_miss = 0;

    mux4in_decoder4out #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .mux_in   (mux_in),
        .mux_sel  (mux_sel),
        .mux_out  (mux_out),
        .dec_code (dec_code),
        .dec_en   (dec_en),
        .dec_out  (dec_out)
`ifdef MUXDEC_VALID_EN
        ,
        .in_valid (in_valid),
        .out_valid(out_valid)
`endif
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [3:0] dec_tbl [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    logic [W-1:0] exp_mux;
    logic [3:0]   exp_dec;
    logic         exp_ov;
    bit           model_live = 0;

    always @(posedge clk) begin
        bit upd;
        upd = 1'b1;
`ifdef MUXDEC_VALID_EN
        upd = in_valid;
`endif
        if (rst) begin
            exp_mux = '0;
            exp_dec = 4'b0000;
            exp_ov  = 1'b0;
        end else begin
            exp_ov = upd;
            if (upd) begin
                exp_mux = W'(mux_in >> (int'(mux_sel) * W));
                exp_dec = dec_en ? dec_tbl[dec_code] : 4'b0000;
            end
        end
        model_live = 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: every falling edge once the model has seen an edge.
    always @(negedge clk) begin
        if (model_live) begin
            chk("model_mux", 32'(mux_out), 32'(exp_mux));
            chk("model_dec", 32'(dec_out), 32'(exp_dec));
`ifdef MUXDEC_VALID_EN
            chk("model_valid", 32'(out_valid), 32'(exp_ov));
`endif
        end
    end

    // Drive inputs at the falling edge, then return just after the next
    // rising edge so registered outputs can be checked against literals.
    task automatic apply(input logic r, input logic [1:0] sel, input logic [4*W-1:0] din,
                         input logic en, input logic [1:0] code, input logic v);
        @(negedge clk);
        rst      = r;
        mux_sel  = sel;
        mux_in   = din;
        dec_en   = en;
        dec_code = code;
`ifdef MUXDEC_VALID_EN
        in_valid = v;
`endif
        @(posedge clk);
        #1;
        $display("vec rst=%0b sel=%0d in=%0h en=%0b code=%0d v=%0b -> mux_out=%0h dec_out=%b",
                 r, sel, din, en, code, v, mux_out, dec_out);
    endtask

    logic [4*W-1:0] ones;

    initial begin
        ones     = '1;
        rst      = 1'b1;
        mux_in   = '0;
        mux_sel  = 2'd0;
        dec_en   = 1'b0;
        dec_code = 2'd0;
`ifdef MUXDEC_VALID_EN
        in_valid = 1'b0;
`endif

        // Reset held two cycles with busy inputs.
        apply(1'b1, 2'd3, ones, 1'b1, 2'd2, 1'b1);
        chk("rst_mux_0", 32'(mux_out), 32'd0);
        chk("rst_dec_0", 32'(dec_out), 32'b0000);
        apply(1'b1, 2'd3, ones, 1'b1, 2'd2, 1'b1);
        chk("rst_mux_1", 32'(mux_out), 32'd0);
        chk("rst_dec_1", 32'(dec_out), 32'b0000);
        // First edge after release captures the inputs.
        apply(1'b0, 2'd3, ones, 1'b1, 2'd2, 1'b1);
        chk("release_mux", 32'(mux_out), 32'(ones[W-1:0]));
        chk("release_dec", 32'(dec_out), 32'b0100);

`ifndef MUXDEC_VALID_EN
        // Exhaustive mux sweep; the model checks every result.
        for (int s = 0; s < 4; s++)
            for (int d = 0; d < 16; d++)
                apply(1'b0, 2'(s), 4'(d), 1'b0, 2'd0, 1'b1);
        apply(1'b0, 2'd2, 4'b0100, 1'b0, 2'd0, 1'b1);
        chk("mux_sel2_0100", 32'(mux_out), 32'd1);
        apply(1'b0, 2'd2, 4'b1011, 1'b0, 2'd0, 1'b1);
        chk("mux_sel2_1011", 32'(mux_out), 32'd0);
        apply(1'b0, 2'd0, 4'b0001, 1'b0, 2'd0, 1'b1);
        chk("mux_sel0_0001", 32'(mux_out), 32'd1);
        apply(1'b0, 2'd3, 4'b0111, 1'b0, 2'd0, 1'b1);
        chk("mux_sel3_0111", 32'(mux_out), 32'd0);
`endif

        // Decoder sweep.
        apply(1'b0, 2'd0, '0, 1'b1, 2'd0, 1'b1);
        chk("dec_code0", 32'(dec_out), 32'b0001);
        apply(1'b0, 2'd1, '0, 1'b1, 2'd1, 1'b1);
        chk("dec_code1", 32'(dec_out), 32'b0010);
        apply(1'b0, 2'd2, '0, 1'b1, 2'd2, 1'b1);
        chk("dec_code2", 32'(dec_out), 32'b0100);
        apply(1'b0, 2'd3, '0, 1'b1, 2'd3, 1'b1);
        chk("dec_code3", 32'(dec_out), 32'b1000);

        // Decoder disable toggling.
        apply(1'b0, 2'd0, ones, 1'b1, 2'd3, 1'b1);
        chk("dec_en1_a", 32'(dec_out), 32'b1000);
        apply(1'b0, 2'd0, ones, 1'b0, 2'd3, 1'b1);
        chk("dec_en0", 32'(dec_out), 32'b0000);
        apply(1'b0, 2'd0, ones, 1'b1, 2'd3, 1'b1);
        chk("dec_en1_b", 32'(dec_out), 32'b1000);

        // Mid-operation reset during a sweep.
        apply(1'b0, 2'd1, ones, 1'b1, 2'd1, 1'b1);
        chk("sweep_pre_dec", 32'(dec_out), 32'b0010);
        apply(1'b1, 2'd2, ones, 1'b1, 2'd2, 1'b1);
        chk("midrst_mux", 32'(mux_out), 32'd0);
        chk("midrst_dec", 32'(dec_out), 32'b0000);
        apply(1'b0, 2'd3, ones, 1'b1, 2'd3, 1'b1);
        chk("resume_mux", 32'(mux_out), 32'(ones[W-1:0]));
        chk("resume_dec", 32'(dec_out), 32'b1000);

`ifdef MUXDEC_VALID_EN
        // Valid-qualified update and hold.
        apply(1'b0, 2'd3, 32'h44332211, 1'b1, 2'd0, 1'b1);
        chk("valid_mux", 32'(mux_out), 32'h44);
        chk("valid_ov1", 32'(out_valid), 32'd1);
        chk("valid_dec", 32'(dec_out), 32'b0001);
        apply(1'b0, 2'd0, 32'h44332211, 1'b1, 2'd2, 1'b0);
        chk("hold_mux", 32'(mux_out), 32'h44);
        chk("hold_ov0", 32'(out_valid), 32'd0);
        chk("hold_dec", 32'(dec_out), 32'b0001);
        apply(1'b0, 2'd1, 32'h44332211, 1'b0, 2'd2, 1'b1);
        chk("lane1_mux", 32'(mux_out), 32'h22);
        chk("lane1_dec", 32'(dec_out), 32'b0000);
        apply(1'b1, 2'd1, 32'h44332211, 1'b1, 2'd2, 1'b0);
        chk("vrst_mux", 32'(mux_out), 32'd0);
        chk("vrst_ov", 32'(out_valid), 32'd0);
`endif

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
